// File: rtl/obj_arb_pkg.sv
// Shared types and defaults for the object-RAM write arbiter.
package obj_arb_pkg;

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_WIN  = 1'b1
    } arb_state_t;

    localparam int NREQ_DEFAULT       = 4;
    localparam int AW_DEFAULT         = 3;
    localparam int DW_DEFAULT         = 13;
    localparam int WIN_CYCLES_DEFAULT = 1600;

    function automatic int win_cnt_width(input int win_cycles);
        return (win_cycles > 2) ? $clog2(win_cycles) : 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int WCW_DEFAULT = win_cnt_width(WIN_CYCLES_DEFAULT);

endpackage

// File: rtl/obj_ram_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick
    import obj_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    logic          hi_valid_s;
    logic [PW-1:0] hi_idx_s;
    logic          lo_valid_s;
    logic [PW-1:0] lo_idx_s;

    // Lowest eligible index at/above ptr wins; otherwise lowest below ptr.
    always_comb begin
        hi_valid_s = 1'b0;
        hi_idx_s   = '0;
        lo_valid_s = 1'b0;
        lo_idx_s   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            hi_valid_s = hi_valid_s | (eligible[i] && (PW'(i) >= ptr));
            hi_idx_s   = (eligible[i] && (PW'(i) >= ptr)) ? PW'(i) : hi_idx_s;
            lo_valid_s = lo_valid_s | (eligible[i] && (PW'(i) < ptr));
            lo_idx_s   = (eligible[i] && (PW'(i) < ptr)) ? PW'(i) : lo_idx_s;
        end
        valid = hi_valid_s | lo_valid_s;
        idx   = hi_valid_s ? hi_idx_s : lo_idx_s;
    end

endmodule

// File: rtl/obj_ram_write_arbiter.sv
// Shares the object-RAM write port among NREQ requesters inside a VS-triggered window.
// Optional OBJARB_OVERRUN_EN: sticky oOverrun plus 16-bit saturating overrun-frame count.
module obj_ram_write_arbiter
    import obj_arb_pkg::*;
#(
    parameter int NREQ       = NREQ_DEFAULT,
    parameter int AW         = AW_DEFAULT,
    parameter int DW         = DW_DEFAULT,
    parameter int WIN_CYCLES = WIN_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iVS,
    input  logic [NREQ-1:0]   iReq,
    input  logic [NREQ*AW-1:0] iAddr,
    input  logic [NREQ*DW-1:0] iData,
    output logic [NREQ-1:0]   oAck,
    output logic              oFrame,
    output logic [AW-1:0]     oObjRam_addr,
    output logic [DW-1:0]     oObjRam_data,
    output logic              oObjRam_we,
    output logic              oOverrun
);

    localparam int WCW = win_cnt_width(WIN_CYCLES);
    localparam int PW  = idx_width(NREQ);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN_CYCLES - 1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(NREQ - 1);

    arb_state_t      state_r;
    logic [WCW-1:0]  win_cnt_r;
    logic            vs_d_r;
    logic [PW-1:0]   ptr_r;

    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] grant_s;
    logic            pick_valid_s;
    logic [PW-1:0]   pick_idx_s;
    logic [AW-1:0]   pick_addr_s;
    logic [DW-1:0]   pick_data_s;
    logic            vs_fall_s;
    logic            win_end_s;

    // A requester whose ack is visible this cycle still holds iReq; mask it out.
    assign eligible_s = iReq & ~oAck;
    assign vs_fall_s  = vs_d_r & ~iVS;
    assign win_end_s  = (win_cnt_r == WIN_LAST);

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .eligible (eligible_s),
        .ptr      (ptr_r),
        .valid    (pick_valid_s),
        .idx      (pick_idx_s)
    );

    // One-hot grant and the granted requester's address/data slice.
    always_comb begin
        grant_s     = '0;
        pick_addr_s = '0;
        pick_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_s[i]  = pick_valid_s && (pick_idx_s == PW'(i));
            pick_addr_s = grant_s[i] ? iAddr[i*AW +: AW] : pick_addr_s;
            pick_data_s = grant_s[i] ? iData[i*DW +: DW] : pick_data_s;
        end
    end

    // Window FSM, grant pointer and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_WAIT;
            win_cnt_r    <= '0;
            vs_d_r       <= 1'b1;
            ptr_r        <= '0;
            oAck         <= '0;
            oFrame       <= 1'b0;
            oObjRam_we   <= 1'b0;
            oObjRam_addr <= '0;
            oObjRam_data <= '0;
        end else begin
            vs_d_r     <= iVS;
            oFrame     <= 1'b0;
            oObjRam_we <= 1'b0;
            oAck       <= '0;
            case (state_r)
                S_WAIT: begin
                    if (vs_fall_s) begin
                        state_r   <= S_WIN;
                        win_cnt_r <= '0;
                        oFrame    <= 1'b1;
                    end
                end
                S_WIN: begin
                    if (pick_valid_s) begin
                        oObjRam_addr <= pick_addr_s;
                        oObjRam_data <= pick_data_s;
                        oObjRam_we   <= 1'b1;
                        oAck         <= grant_s;
                        ptr_r        <= (pick_idx_s == PTR_LAST) ? '0 : pick_idx_s + 1'b1;
                    end
                    // Further VS edges are ignored; only the count closes the window.
                    if (win_end_s) begin
                        state_r   <= S_WAIT;
                        win_cnt_r <= '0;
                    end else begin
                        win_cnt_r <= win_cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_WAIT;
                    win_cnt_r <= '0;
                end
            endcase
        end
    end

`ifdef OBJARB_OVERRUN_EN
    logic            overrun_r;
    logic [15:0]     overrun_cnt_r;
    logic [NREQ-1:0] unserved_s;

    // Requests left over after the last slot's grant are what spill into the next frame.
    assign unserved_s = eligible_s & ~grant_s;

    // Sticky overrun flag and saturating count of overrun frames.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r     <= 1'b0;
            overrun_cnt_r <= 16'd0;
        end else if ((state_r == S_WIN) && win_end_s && (unserved_s != '0)) begin
            overrun_r     <= 1'b1;
            overrun_cnt_r <= (overrun_cnt_r == 16'hFFFF) ? overrun_cnt_r : overrun_cnt_r + 16'd1;
        end else begin
            overrun_r     <= overrun_r;
            overrun_cnt_r <= overrun_cnt_r;
        end
    end

    assign oOverrun = overrun_r;
`else
    assign oOverrun = 1'b0;
`endif

endmodule
